// File: rtl/vec_chunk_fifo.sv
// Chunked vector buffer: stores WorkingRegs-byte chunks in a circular array and flags whole vectors.
// Optional sticky overflow/underflow outputs are enabled by VEC_CHUNK_FIFO_ERR_FLAGS_EN.
module vec_chunk_fifo #(
   parameter int InVecLength = 16,
   parameter int WorkingRegs = 4,
   parameter int VecDepth    = 2
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               wr_en,
   input  logic signed [WorkingRegs-1:0][7:0] wr_data,
   input  logic                               rd_req,
   output logic signed [WorkingRegs-1:0][7:0] rd_data,
   output logic                               rd_valid,
   output logic                               vec_ready,
   output logic                               wr_vec_done,
   output logic                               full,
   output logic                               empty
`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
  ,output logic                               overflow,
   output logic                               underflow
`endif
);

   localparam int CPV   = InVecLength / WorkingRegs;
   localparam int SLOTS = VecDepth * CPV;
   localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CW    = $clog2(SLOTS + 1);
   localparam int VW    = $clog2(VecDepth + 1);
   localparam int IW    = (CPV > 1) ? $clog2(CPV) : 1;
   localparam int DW    = WorkingRegs * 8;

   logic [DW-1:0] mem [SLOTS];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [IW-1:0] widx_q, widx_d, ridx_q, ridx_d;
   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q, wvd_q, full_q, empty_q, vready_q;
   logic          rd_acc, wr_acc, wr_wrap, rd_wrap;

   always_comb begin
      rd_acc   = rd_req && !empty_q;
      // a read at full frees the slot the write lands in
      wr_acc   = wr_en && (!full_q || rd_acc);
      wr_wrap  = wr_acc && (widx_q == IW'(CPV - 1));
      rd_wrap  = rd_acc && (ridx_q == IW'(CPV - 1));
      cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
      vcnt_d   = vcnt_q + VW'(wr_wrap) - VW'(rd_wrap);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      widx_d   = widx_q;
      ridx_d   = ridx_q;
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == PW'(SLOTS - 1)) ? '0 : wr_ptr_q + 1'b1;
         widx_d   = wr_wrap ? '0 : widx_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == PW'(SLOTS - 1)) ? '0 : rd_ptr_q + 1'b1;
         ridx_d   = rd_wrap ? '0 : ridx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         vcnt_q     <= '0;
         widx_q     <= '0;
         ridx_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wvd_q      <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         vready_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         vcnt_q     <= vcnt_d;
         widx_q     <= widx_d;
         ridx_q     <= ridx_d;
         if (rd_acc) rd_data_q <= mem[rd_ptr_q];
         rd_valid_q <= rd_acc;
         wvd_q      <= wr_wrap;
         full_q     <= (cnt_d == CW'(SLOTS));
         empty_q    <= (cnt_d == '0);
         vready_q   <= (vcnt_d != '0);
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign wr_vec_done = wvd_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign vec_ready   = vready_q;

`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (wr_en && !wr_acc);
         udf_q <= udf_q | (rd_req && empty_q);
      end
   end

   assign overflow  = ovf_q;
   assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// Scoreboard bench for vec_chunk_fifo (8/4/2): directed plan then random traffic vs. a queue model.
module tb_vec_chunk_fifo;
   localparam int IVL = 8, WR = 4, VD = 2;
   localparam int CPV = IVL / WR, SLOTS = VD * CPV, DW = WR * 8;

   logic                      clk_in = 1'b0;
   logic                      rst_in, wr_en, rd_req;
   logic signed [WR-1:0][7:0] wr_data, rd_data;
   logic                      rd_valid, vec_ready, wr_vec_done, full, empty;
`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
   logic                      overflow, underflow;
`endif

   vec_chunk_fifo #(.InVecLength(IVL), .WorkingRegs(WR), .VecDepth(VD)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data),
      .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .vec_ready(vec_ready), .wr_vec_done(wr_vec_done), .full(full), .empty(empty)
`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
     ,.overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic          rv;
      logic [DW-1:0] rd;
      logic          vr, fu, em, wvd, ovf, udf;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] chunks[$];
   logic [DW-1:0] last_rd;
   int            wtot, rtot;
   logic          ovf_m, udf_m;
   int            n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a chunk queue plus lifetime write/read totals; whole vectors = total/CPV.
   task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] d);
      exp_t e;
      logic  ra, wa;
      rst_in = rst; wr_en = wr; rd_req = rd; wr_data = d;
      if (!rst) begin
         chunks.delete(); wtot = 0; rtot = 0; last_rd = '0; ovf_m = 0; udf_m = 0;
         e.rv = 0; e.wvd = 0;
      end else begin
         ra = rd && (chunks.size() > 0);
         wa = wr && (chunks.size() < SLOTS || ra);
         udf_m |= rd && (chunks.size() == 0);
         ovf_m |= wr && !wa;
         if (ra) begin last_rd = chunks.pop_front(); rtot++; end
         if (wa) begin chunks.push_back(d); wtot++; end
         e.rv  = ra;
         e.wvd = wa && (wtot % CPV == 0);
      end
      e.rd  = last_rd;
      e.vr  = (wtot / CPV - rtot / CPV) != 0;
      e.fu  = chunks.size() == SLOTS;
      e.em  = chunks.size() == 0;
      e.ovf = ovf_m;
      e.udf = udf_m;
      exp_q.push_back(e);
      @(posedge clk_in);
      #2;
   endtask

   // Monitor: each expectation applies to the cycle right after its stimulus edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", DW'(rd_valid), DW'(e.rv));
            if (e.rv || !rst_in) chk("rd_data", rd_data, e.rd);
            else chk("rd_data_hold", rd_data, e.rd);
            chk("vec_ready", DW'(vec_ready), DW'(e.vr));
            chk("full", DW'(full), DW'(e.fu));
            chk("empty", DW'(empty), DW'(e.em));
            chk("wr_vec_done", DW'(wr_vec_done), DW'(e.wvd));
`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
            chk("overflow", DW'(overflow), DW'(e.ovf));
            chk("underflow", DW'(underflow), DW'(e.udf));
`endif
         end
      end
   end

   function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   initial begin
      int wp, rp;
      wtot = 0; rtot = 0; last_rd = '0; ovf_m = 0; udf_m = 0;
      cycle(0, 0, 0, '0);
      cycle(0, 0, 0, '0);
      // two chunks complete one vector, then read it back
      cycle(1, 1, 0, mk(1, 2, 3, 4));
      cycle(1, 1, 0, mk(5, 6, 7, 8));
      cycle(1, 0, 1, '0);
      cycle(1, 0, 1, '0);
      cycle(1, 0, 0, '0);
      // fill, overflow attempt, drain
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, mk(16 + i, 32 + i, 48 + i, 64 + i));
      cycle(1, 1, 0, mk(9, 9, 9, 9));
      for (int i = 0; i < 4; i++) cycle(1, 0, 1, '0);
      // full with simultaneous read/write, then wrap-around drain
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, mk(100 + i, 1, 2, 3));
      cycle(1, 1, 1, mk(200, 201, 202, 203));
      cycle(1, 1, 1, mk(210, 211, 212, 213));
      for (int i = 0; i < 5; i++) cycle(1, 0, 1, '0);
      // empty read, then reset with a partial vector stored
      cycle(1, 0, 1, '0);
      cycle(1, 0, 0, '0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, mk(40 + i, 41, 42, 43));
      cycle(0, 0, 0, '0);
      cycle(1, 0, 1, '0);
      cycle(1, 0, 0, '0);
      // random phases alternating write-heavy and read-heavy traffic
      for (int i = 0; i < 600; i++) begin
         wp = ((i / 40) % 2 == 0) ? 75 : 30;
         rp = 100 - wp;
         cycle(($urandom_range(0, 149) != 0),
               ($urandom_range(0, 99) < wp),
               ($urandom_range(0, 99) < rp),
               DW'($urandom));
      end
      cycle(1, 0, 0, '0);
      repeat (3) @(posedge clk_in);
      #3;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vec_chunk_fifo.md
Name: vec_chunk_fifo

Overview:
- Chunked vector buffer placed between two streaming layers.
- Write side: takes WorkingRegs-byte chunks from an upstream layer's chunk-out strobe and write-data bus.
- Read side: answers a downstream layer's chunk-in requests with single-cycle registered read data.
- Asserts vec_ready while at least one complete InVecLength vector is held, to drive the downstream in_data_ready.

Parameters:
- InVecLength, 16, bytes per vector; must be a multiple of WorkingRegs.
- WorkingRegs, 4, bytes per chunk (the bus width in bytes).
- VecDepth, 2, number of whole vectors stored; total chunk slots = VecDepth*InVecLength/WorkingRegs.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous reset, active-low
- wr_en  input  1  write one chunk this cycle; connects to upstream req_chunk_out
- wr_data  input  signed [WorkingRegs-1:0][7:0]  write chunk
- rd_req  input  1  request one chunk; connects to downstream req_chunk_in
- rd_data  output  signed [WorkingRegs-1:0][7:0]  read chunk, registered
- rd_valid  output  1  rd_data holds a chunk popped the previous cycle
- vec_ready  output  1  at least one complete vector is stored
- wr_vec_done  output  1  one-cycle pulse when a write completes a vector
- full  output  1  no free chunk slot
- empty  output  1  no stored chunk

Behaviour:
- Reset is sampled at posedge with rst_in==0.
  - Pointers, chunk count, complete-vector count and chunk indices all clear to 0.
  - rd_data=0, rd_valid=0, vec_ready=0, wr_vec_done=0, full=0, empty=1.
  - Reset mid-operation discards all contents, including partial vectors.
- Storage is a circular array of chunk slots.
  - wr_ptr and rd_ptr wrap from last slot to 0.
  - chunk_cnt runs 0..slots.
- Write: accepted when wr_en && (!full || read accepted same cycle).
  - Store at wr_ptr, advance wr_ptr, advance wr_chunk_idx.
  - When wr_chunk_idx wraps from ChunksPerVec-1 to 0: increment vec_cnt and pulse wr_vec_done next cycle.
  - Write when full with no same-cycle read: dropped, no state change.
- Read: accepted when rd_req && !empty.
  - In the next cycle, rd_data = slot[rd_ptr] and rd_valid=1; rd_ptr and rd_chunk_idx advance.
  - When rd_chunk_idx wraps, vec_cnt decrements.
  - rd_req when empty: rd_valid=0 next cycle, rd_data holds its previous value.
  - rd_valid is 0 in any cycle not preceded by an accepted read.
- Simultaneous accepted read and write:
  - chunk_cnt unchanged.
  - Allowed at full, since the read frees the slot.
  - At empty the read is rejected; no write-through bypass.
  - vec_cnt may increment and decrement in the same cycle; the net change is applied.
- vec_ready = (vec_cnt != 0), registered from post-update counts.
  - It stays high while the last chunk of a vector is outstanding.
  - It drops the cycle after the final chunk of the last complete vector is read.
- full = (chunk_cnt == slots); empty = (chunk_cnt == 0); both registered.
- A partial vector (some chunks written) never raises vec_ready but is readable chunk-wise.
- Width: chunk_cnt is $clog2(slots+1) bits; vec_cnt is $clog2(VecDepth+1) bits; chunk indices are $clog2(ChunksPerVec) bits, minimum 1 bit.
- Data is passed bit-exact; no sign handling.

Optional Feature:
- Macro VEC_CHUNK_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow and underflow, 1 bit each, both sticky.
  - overflow sets on a dropped write.
  - underflow sets on rd_req while empty.
  - Both clear only on reset.
- Undefined: ports absent; dropped writes and empty reads are silently ignored as above.

Test Plan:
- Params 8/4/2 (ChunksPerVec=2, slots=4). Reset, write chunks {1,2,3,4},{5,6,7,8} on consecutive cycles -> wr_vec_done pulses once after the 2nd write; vec_ready=1; empty=0; full=0.
- Continue: rd_req for 2 cycles -> rd_data {1,2,3,4} then {5,6,7,8} with rd_valid=1 on the cycles after each req; vec_ready=0 and empty=1 after the 2nd.
- Fill 4 chunks, then 5th write {9,9,9,9} with no read -> full=1, write dropped (overflow=1 if enabled); subsequent 4 reads return the original 4 chunks in order.
- At full, assert wr_en and rd_req in the same cycle -> write accepted, oldest chunk returned, full stays 1, chunk_cnt stays 4; wrap-around read order is correct.
- rd_req with empty=1 -> rd_valid=0 next cycle, rd_data unchanged (underflow=1 if enabled).
- Write 3 chunks, drive rst_in=0 for one cycle -> all outputs return to reset values, and the next read request yields rd_valid=0.
